// File: rtl/jam_pkg.sv
// Shared types and width helpers for the jam_gen job-assignment solver.
package jam_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StAcc,
    StCmp,
    StNext,
    StDone
  } jam_state_e;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int unsigned idx_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Wide enough that n entries of (2^cost_w - 1) never overflow.
  function automatic int unsigned sum_width(input int unsigned n, input int unsigned cost_w);
    return cost_w + $clog2(n);
  endfunction

endpackage

// File: rtl/jam_gen_if.sv
// Start/Busy handshake, cost-lookup port and result bus of jam_gen.
// best_perm exists only when JAM_BEST_PERM_EN is defined.
interface jam_gen_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned COST_W = 7,
  parameter int unsigned CNT_W  = 16
);
  import jam_pkg::*;

  localparam int unsigned IDX_W = idx_width(N);
  localparam int unsigned SUM_W = sum_width(N, COST_W);

  logic              start;
  logic              mode;
  logic [IDX_W-1:0]  w;
  logic [IDX_W-1:0]  j;
  logic [COST_W-1:0] cost;
  logic              busy;
  logic [SUM_W-1:0]  best_cost;
  logic [CNT_W-1:0]  match_count;
  logic              valid;
`ifdef JAM_BEST_PERM_EN
  logic [N*IDX_W-1:0] best_perm;
`endif

  modport master (
    input  start,
    input  mode,
    input  cost,
    output w,
    output j,
    output busy,
    output best_cost,
    output match_count,
`ifdef JAM_BEST_PERM_EN
    output best_perm,
`endif
    output valid
  );

  modport slave (
    output start,
    output mode,
    output cost,
    input  w,
    input  j,
    input  busy,
    input  best_cost,
    input  match_count,
`ifdef JAM_BEST_PERM_EN
    input  best_perm,
`endif
    input  valid
  );

endinterface

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a permutation, plus whether one exists.
module jam_next_perm #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0][IDX_W-1:0] perm_i,
  output logic                    has_pivot_o,
  output logic [N-1:0][IDX_W-1:0] perm_o
);

  logic [IDX_W-1:0]          piv;
  logic [IDX_W-1:0]          succ;
  logic [N-1:0][IDX_W-1:0]   swapped;

  always_comb begin
    has_pivot_o = 1'b0;
    piv         = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_i[i] < perm_i[i+1]) begin
        has_pivot_o = 1'b1;
        piv         = IDX_W'(i);
      end
    end

    // The suffix after the pivot is descending, so the last larger entry is the successor.
    succ = piv;
    for (int i = 0; i < N; i++) begin
      if ((IDX_W'(i) > piv) && (perm_i[i] > perm_i[piv])) begin
        succ = IDX_W'(i);
      end
    end

    swapped       = perm_i;
    swapped[piv]  = perm_i[succ];
    swapped[succ] = perm_i[piv];

    perm_o = swapped;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) > piv) begin
        perm_o[i] = swapped[piv + IDX_W'(N - i)];
      end
    end
  end

endmodule

// File: rtl/jam_gen.sv
// Job-assignment solver: walks all N! permutations lexicographically and reports the optimal
// total cost and its multiplicity. Define JAM_BEST_PERM_EN to also export the best assignment.
module jam_gen
  import jam_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned COST_W = 7,
  parameter int unsigned CNT_W  = 16
) (
  input  logic      clk_i,
  input  logic      rst_i,
  jam_gen_if.master bus
);

  localparam int unsigned      IDX_W = idx_width(N);
  localparam int unsigned      SUM_W = sum_width(N, COST_W);
  localparam logic [IDX_W-1:0] KLast = IDX_W'(N - 1);

  typedef logic [N-1:0][IDX_W-1:0] perm_t;

  jam_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  perm_t            perm_q, perm_d, perm_next;
  logic             has_pivot;
  logic [IDX_W-1:0] k_q, k_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] best_q, best_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             better;
  logic [IDX_W-1:0] w, j;
`ifdef JAM_BEST_PERM_EN
  perm_t            best_perm_q, best_perm_d;
`endif

  function automatic perm_t identity_perm();
    perm_t p;
    for (int i = 0; i < N; i++) begin
      p[i] = IDX_W'(i);
    end
    return p;
  endfunction

  jam_next_perm #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_next_perm (
    .perm_i      (perm_q),
    .has_pivot_o (has_pivot),
    .perm_o      (perm_next)
  );

  assign better = (mode_q == MODE_MAX) ? (sum_q > best_q) : (sum_q < best_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    perm_d  = perm_q;
    k_d     = k_q;
    sum_d   = sum_q;
    best_d  = best_q;
    count_d = count_q;
`ifdef JAM_BEST_PERM_EN
    best_perm_d = best_perm_q;
`endif
    w = '0;
    j = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          state_d = StInit;
        end
      end
      StInit: begin
        perm_d  = identity_perm();
        best_d  = (mode_q == MODE_MAX) ? {SUM_W{1'b0}} : {SUM_W{1'b1}};
        count_d = '0;
        sum_d   = '0;
        k_d     = '0;
        state_d = StAcc;
      end
      StAcc: begin
        w     = k_q;
        j     = perm_q[k_q];
        sum_d = sum_q + SUM_W'(bus.cost);
        k_d   = k_q + 1'b1;
        if (k_q == KLast) begin
          state_d = StCmp;
        end
      end
      StCmp: begin
        // count == 0 seeds the first permutation regardless of the sentinel in best_q.
        if (better || (count_q == '0)) begin
          best_d  = sum_q;
          count_d = CNT_W'(1);
`ifdef JAM_BEST_PERM_EN
          best_perm_d = perm_q;
`endif
        end else if ((sum_q == best_q) && (count_q != {CNT_W{1'b1}})) begin
          count_d = count_q + 1'b1;
        end
        state_d = has_pivot ? StNext : StDone;
      end
      StNext: begin
        perm_d  = perm_next;
        sum_d   = '0;
        k_d     = '0;
        state_d = StAcc;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= MODE_MIN;
      perm_q  <= identity_perm();
      k_q     <= '0;
      sum_q   <= '0;
      best_q  <= '0;
      count_q <= '0;
`ifdef JAM_BEST_PERM_EN
      best_perm_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      perm_q  <= perm_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      best_q  <= best_d;
      count_q <= count_d;
`ifdef JAM_BEST_PERM_EN
      best_perm_q <= best_perm_d;
`endif
    end
  end

  assign bus.w           = w;
  assign bus.j           = j;
  assign bus.busy        = (state_q != StIdle) && (state_q != StDone);
  assign bus.valid       = (state_q == StDone);
  assign bus.best_cost   = best_q;
  assign bus.match_count = count_q;
`ifdef JAM_BEST_PERM_EN
  assign bus.best_perm   = best_perm_q;
`endif

endmodule
